// File: rtl/imem_refill_responder.sv
// Instruction-store refill responder: answers fetch misses with one LINE_WORDS-beat burst per request.
// Latency: first beat LATENCY+1 cycles after acceptance; IMEM_REFILL_CRITICAL_FIRST_EN starts the burst at the missed word.
// Backpressure: beats hold while inp_rspReady is low; requests are refused (not queued) outside IDLE.
module imem_refill_responder #(
   parameter int MEM_WORDS  = 256,
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 3
) (
   input  logic                          inp_clk,
   input  logic                          inp_rst,
   input  logic                          inp_reqValid,
   input  logic [15:0]                   inp_reqAddr,
   output logic                          out_reqReady,
   output logic                          out_rspValid,
   output logic [15:0]                   out_rspData,
   output logic [$clog2(LINE_WORDS)-1:0] out_rspIdx,
   output logic                          out_rspLast,
   input  logic                          inp_rspReady,
   input  logic                          inp_loadEn,
   input  logic [$clog2(MEM_WORDS)-1:0]  inp_loadAddr,
   input  logic [15:0]                   inp_loadData
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int IW = $clog2(LINE_WORDS);
   localparam int LW = AW - IW;

   typedef enum logic [1:0] {IDLE, WAIT, BURST} stateT;

   logic [15:0]   mem [MEM_WORDS];
   stateT         state, nextState;
   logic [3:0]    cnt, cntNext;
   logic [LW-1:0] lineReg, reqLine, rdLine;
   logic [IW-1:0] offReg, reqOff, rdOff, beatCnt, beatNext;
   logic [AW-1:0] reqWord;
   logic          loadBeat, finish, accept;
   logic          rspValid, rspLast;
   logic [15:0]   rspData;
   logic [IW-1:0] rspIdx;
   logic          unusedBits;

   // Upper address bits beyond the store are dropped; byte bit 0 is meaningless for 16-bit words.
   assign reqWord    = inp_reqAddr[AW:1];
   assign reqLine    = reqWord[AW-1:IW];
   assign unusedBits = ^{inp_reqAddr[15:AW+1], inp_reqAddr[0], reqWord[IW-1:0]};

`ifdef IMEM_REFILL_CRITICAL_FIRST_EN
   assign reqOff = reqWord[IW-1:0];
`else
   assign reqOff = '0;
`endif

   always_ff @(posedge inp_clk) begin
      if (inp_rst) state <= IDLE;
      else         state <= nextState;
   end

   always_comb begin
      nextState = state;
      cntNext   = cnt;
      loadBeat  = 1'b0;
      finish    = 1'b0;
      accept    = 1'b0;
      rdLine    = lineReg;
      rdOff     = offReg;
      beatNext  = '0;
      case (state)
         IDLE: begin
            if (inp_reqValid) begin
               accept = 1'b1;
               if (LATENCY == 0) begin
                  loadBeat  = 1'b1;
                  rdLine    = reqLine;
                  rdOff     = reqOff;
                  nextState = BURST;
               end else begin
                  cntNext   = 4'(LATENCY - 1);
                  nextState = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               loadBeat  = 1'b1;
               nextState = BURST;
            end else begin
               cntNext = cnt - 4'd1;
            end
         end
         BURST: begin
            if (inp_rspReady) begin
               if (rspLast) begin
                  finish    = 1'b1;
                  nextState = IDLE;
               end else begin
                  loadBeat = 1'b1;
                  rdOff    = rspIdx + IW'(1);
                  beatNext = beatCnt + IW'(1);
               end
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Store is not reset; a beat read in the same cycle as a write sees the old word.
   always_ff @(posedge inp_clk) begin
      if (inp_loadEn) mem[inp_loadAddr] <= inp_loadData;
   end

   always_ff @(posedge inp_clk) begin
      if (inp_rst) begin
         cnt      <= '0;
         beatCnt  <= '0;
         lineReg  <= '0;
         offReg   <= '0;
         rspValid <= 1'b0;
         rspData  <= '0;
         rspIdx   <= '0;
         rspLast  <= 1'b0;
      end else begin
         cnt <= cntNext;
         if (accept) begin
            lineReg <= reqLine;
            offReg  <= reqOff;
         end
         // Last is tied to the beat count, not the offset, so wrapped bursts end correctly.
         if (loadBeat) begin
            rspValid <= 1'b1;
            rspData  <= mem[{rdLine, rdOff}];
            rspIdx   <= rdOff;
            beatCnt  <= beatNext;
            rspLast  <= (beatNext == IW'(LINE_WORDS - 1));
         end else if (finish) begin
            rspValid <= 1'b0;
            rspLast  <= 1'b0;
         end
      end
   end

   assign out_reqReady = (state == IDLE);
   assign out_rspValid = rspValid;
   assign out_rspData  = rspData;
   assign out_rspIdx   = rspIdx;
   assign out_rspLast  = rspLast;

endmodule
